// File: rtl/locked_sec_pkg.sv
// Shared types and helpers for the key-locked SEC pipeline: FSM states,
// the unlocking LUT key, and the H-matrix column generator.
package locked_sec_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] LUT_KEY = 4'b0110;

    // Column for data bit j: the j-th integer >= 3 that is not a power of two.
    function automatic int h_col(input int j);
        int n;
        int res;
        n   = 0;
        res = 0;
        for (int c = 3; c < 256; c++) begin
            if ((c & (c - 1)) != 0) begin
                if (n == j && res == 0) res = c;
                n++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sec_syndrome.sv
// Combinational syndrome H*d ^ chk; bit 0 is routed through the 4-entry
// LUT key so that only the correct key yields the true parity-0 check.
module sec_syndrome
    import locked_sec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 6
) (
    input  logic [DATA_W-1:0] d,
    input  logic [CHK_W-1:0]  chk,
    input  logic [3:0]        lut_key,
    output logic [CHK_W-1:0]  syn
);

    logic [CHK_W-1:0] contrib [DATA_W];
    logic [CHK_W-1:0] hd;

    for (genvar j = 0; j < DATA_W; j++) begin : g_col
        localparam logic [CHK_W-1:0] COL = CHK_W'(h_col(j));
        assign contrib[j] = d[j] ? COL : '0;
    end

    always_comb begin
        hd = '0;
        for (int j = 0; j < DATA_W; j++) hd = hd ^ contrib[j];
        syn    = hd ^ chk;
        syn[0] = lut_key[{hd[0], chk[0]}];
    end

endmodule

// File: rtl/locked_sec_pipe.sv
// Key-locked two-stage SEC decoder with valid/ready handshake.
// Optional corrected-error counter enabled by defining LOCKED_SEC_ERRCNT_EN.
module locked_sec_pipe
    import locked_sec_pkg::*;
#(
    parameter int              DATA_W       = 32,
    parameter int              CHK_W        = 6,
    parameter logic [DATA_W-1:0] IN_KEY_MASK  = '1,
    parameter logic [DATA_W-1:0] OUT_KEY_MASK = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    input  logic              key_shift,
    input  logic              key_commit,
    input  logic              key_clear,
    output logic              key_err,
    output logic              active,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    output logic [15:0]       err_cnt
);

    localparam int KEY_W = 2 * DATA_W + 4;
    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] KEY_FULL = CNT_W'(KEY_W);

    state_t            state;
    logic [KEY_W-1:0]  key;
    logic [CNT_W-1:0]  key_cnt;
    logic [DATA_W-1:0] key_in_part;
    logic [DATA_W-1:0] key_out_part;
    logic [3:0]        lut_key;

    assign key_in_part  = key[DATA_W-1:0];
    assign key_out_part = key[2*DATA_W-1:DATA_W];
    assign lut_key      = key[KEY_W-1:2*DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            active  <= 1'b0;
            key     <= '0;
            key_cnt <= '0;
            key_err <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (key_clear) begin
                        key     <= '0;
                        key_cnt <= '0;
                    end else if (key_commit) begin
                        if (key_cnt == KEY_FULL) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end else if (key_shift) begin
                        key <= {key[KEY_W-2:0], key_in};
                        if (key_cnt != KEY_FULL) key_cnt <= key_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (key_clear) begin
                        key     <= '0;
                        key_cnt <= '0;
                        state   <= LOAD;
                        active  <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    logic              vld_p1;
    logic [DATA_W-1:0] d_p1;
    logic [CHK_W-1:0]  syn_p1;
    logic [DATA_W-1:0] d_in;
    logic [CHK_W-1:0]  syn_in;
    logic              adv_p2;
    logic              accept;

    assign adv_p2   = !out_valid || out_ready;
    assign in_ready = active && (!vld_p1 || adv_p2);
    assign accept   = in_valid && in_ready;
    assign d_in     = in_data ^ (key_in_part & IN_KEY_MASK);

    // Stage 1: input key gating and syndrome
    sec_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syndrome (
        .d       (d_in),
        .chk     (in_chk),
        .lut_key (lut_key),
        .syn     (syn_in)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            d_p1   <= d_in;
            syn_p1 <= syn_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (adv_p2) out_valid <= vld_p1;
        end
    end

    // Stage 2: single-bit correction and output key gating
    logic [DATA_W-1:0] flip;
    logic              corr_c;
    logic              uncorr_c;

    for (genvar j = 0; j < DATA_W; j++) begin : g_flip
        localparam logic [CHK_W-1:0] COL = CHK_W'(h_col(j));
        assign flip[j] = (syn_p1 == COL);
    end

    assign corr_c   = |flip;
    assign uncorr_c = (syn_p1 != '0) && !corr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
        end else if (adv_p2 && vld_p1) begin
            out_data   <= d_p1 ^ flip ^ (key_out_part & OUT_KEY_MASK);
            out_corr   <= corr_c;
            out_uncorr <= uncorr_c;
        end
    end

`ifdef LOCKED_SEC_ERRCNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || key_clear) err_cnt <= '0;
        else if (out_valid && out_ready && out_corr) err_cnt <= sat_inc(err_cnt);
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_locked_sec_pipe.sv
// Scoreboard bench for locked_sec_pipe: key loading, correction, key gating,
// stall behaviour, reset/clear flushing and the optional error counter.
module tb_locked_sec_pipe;
    import locked_sec_pkg::*;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 6;
    localparam int KEY_W  = 2 * DATA_W + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_in, key_shift, key_commit, key_clear;
    logic              key_err, active;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_corr, out_uncorr;
    logic [15:0]       err_cnt;

    locked_sec_pipe #(.DATA_W(DATA_W), .CHK_W(CHK_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_shift  (key_shift),
        .key_commit (key_commit),
        .key_clear  (key_clear),
        .key_err    (key_err),
        .active     (active),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_chk     (in_chk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corr;
        logic              uncorr;
    } exp_t;

    exp_t              sb[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] cur_in_k, cur_out_k;
    logic [3:0]        cur_lut;
    logic              held = 1'b0;
    exp_t              h;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CHK_W-1:0] col(input int j);
        int c = 2;
        int k = -1;
        while (k < j) begin
            c++;
            if (c != 4 && c != 8 && c != 16 && c != 32 && c != 64) k++;
        end
        return c[CHK_W-1:0];
    endfunction

    function automatic logic [CHK_W-1:0] enc(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] r = '0;
        for (int j = 0; j < DATA_W; j++) if (d[j]) r = r ^ col(j);
        return r;
    endfunction

    function automatic exp_t model(input logic [DATA_W-1:0] din, input logic [CHK_W-1:0] c);
        exp_t             r;
        logic [CHK_W-1:0] hd, s;
        logic [DATA_W-1:0] dd;
        dd = din ^ cur_in_k;
        hd = enc(dd);
        s  = hd ^ c;
        s[0] = cur_lut[{hd[0], c[0]}];
        r.data = dd; r.corr = 1'b0; r.uncorr = 1'b0;
        if (s != '0) begin
            for (int j = 0; j < DATA_W; j++)
                if (s == col(j)) begin r.data[j] = ~r.data[j]; r.corr = 1'b1; end
            if (!r.corr) r.uncorr = 1'b1;
        end
        r.data = r.data ^ cur_out_k;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (held) begin
                check("stall_vld", out_valid, 1);
                check("stall_data", out_data, h.data);
                check("stall_corr", out_corr, h.corr);
                check("stall_uncorr", out_uncorr, h.uncorr);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_corr", out_corr, e.corr);
                    check("out_uncorr", out_uncorr, e.uncorr);
                end
            end
            held = out_valid && !out_ready;
            h    = '{data: out_data, corr: out_corr, uncorr: out_uncorr};
        end else begin
            held = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; key_shift = 1'b0; key_commit = 1'b0;
        key_clear = 1'b0; key_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic load_key(input logic [DATA_W-1:0] ik, input logic [DATA_W-1:0] ok, input logic [3:0] lut);
        logic [KEY_W-1:0] kv;
        cur_in_k = ik; cur_out_k = ok; cur_lut = lut;
        kv = {lut, ok, ik};
        for (int i = KEY_W - 1; i >= 0; i--) begin
            key_shift = 1'b1; key_in = kv[i];
            @(posedge clk); #1;
        end
        key_shift = 1'b0; key_commit = 1'b1;
        @(posedge clk); #1 key_commit = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c, input exp_t e);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_chk = c;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic send_m(input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c);
        send(d, c, model(d, c));
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] d0, d;
        exp_t              e;
        d0 = 32'hDEADBEEF;
        cur_in_k = '0; cur_out_k = '0; cur_lut = LUT_KEY;
        in_data = '0; in_chk = '0;
        do_reset();

        @(negedge clk);
        check("rst_active", active, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_key_err", key_err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_corr", out_corr, 0);
        @(posedge clk); #1;

        // Short key: commit rejected
        for (int i = 0; i < 10; i++) begin
            key_shift = 1'b1; key_in = 1'b1;
            @(posedge clk); #1;
        end
        key_shift = 1'b0; key_commit = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 key_commit = 1'b0;
        @(negedge clk);
        check("short_key_err", key_err, 1);
        check("short_active", active, 0);
        check("short_in_ready", in_ready, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("key_err_pulse", key_err, 0);
        @(posedge clk); #1;

        // Correct key, single-bit correction with latency
        do_reset();
        load_key('0, '0, LUT_KEY);
        @(negedge clk);
        check("active_on", active, 1);
        @(posedge clk); #1;
        e = '{data: d0, corr: 1'b1, uncorr: 1'b0};
        send(d0 ^ 32'h20, enc(d0), e);
        @(negedge clk);
        check("lat_c1", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_c2", out_valid, 1);
        @(posedge clk); #1;
        drain();

        // Double errors alias onto a column; chk[0] error is uncorrectable
        e = '{data: d0 ^ 32'h7, corr: 1'b1, uncorr: 1'b0};
        send(d0 ^ 32'h3, enc(d0), e);
        send(d0 ^ 32'h5, enc(d0), e);
        e = '{data: d0, corr: 1'b0, uncorr: 1'b1};
        send(d0, enc(d0) ^ 6'h1, e);
        drain();

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            send_m(d, enc(d));
            send_m(d ^ (32'h1 << $urandom_range(0, DATA_W - 1)), enc(d));
        end
        drain();

        // Back-to-back stream with output stall
        fork
            for (int i = 0; i < 4; i++) begin
                d = 32'h1000_0000 * (i + 1) + 32'h11 * i;
                send_m(d, enc(d));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Output key bit 0
        do_reset();
        load_key('0, 32'h1, LUT_KEY);
        e = '{data: 32'h1, corr: 1'b0, uncorr: 1'b0};
        send('0, '0, e);
        drain();

        // Input key and wrong LUT key
        do_reset();
        load_key(32'hA5A5_0F0F, 32'h0000_FF00, LUT_KEY);
        d = 32'h1234_5678;
        send_m(d, enc(d ^ 32'hA5A5_0F0F));
        send_m(d, enc(d));
        drain();
        do_reset();
        load_key('0, '0, 4'b1001);
        send_m(d0, enc(d0));
        drain();

        // Reset with words in flight
        do_reset();
        load_key('0, '0, LUT_KEY);
        out_ready = 1'b0;
        send_m(d0, enc(d0));
        send_m(d0, enc(d0));
        do_reset();
        @(negedge clk);
        check("rst_flush_vld", out_valid, 0);
        check("rst_flush_ready", in_ready, 0);
        @(posedge clk); #1;

        // Error counter then key_clear
        load_key('0, '0, LUT_KEY);
        for (int i = 0; i < 3; i++) send_m(d0 ^ (32'h1 << (i * 7)), enc(d0));
        drain();
        @(negedge clk);
`ifdef LOCKED_SEC_ERRCNT_EN
        check("err_cnt_3", err_cnt, 3);
`else
        check("err_cnt_off", err_cnt, 0);
`endif
        @(posedge clk); #1;
        send_m(d0, enc(d0));
        key_clear = 1'b1;
        @(posedge clk); #1 key_clear = 1'b0;
        sb.delete();
        @(negedge clk);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_active", active, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("load_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
